// File: rtl/serial_pkg.sv
// Shared definitions for the serial link arbiter: state codes, counter
// widths and the zero-to-one clamp applied to the timing parameters.
package serial_pkg;

    localparam int CNT_W  = 32;
    localparam int NCYC_W = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // A phase length of zero clocks is not meaningful; it runs as one clock.
    function automatic logic [CNT_W-1:0] clamp_n(input logic [CNT_W-1:0] n);
        return (n == '0) ? CNT_W'(1) : n;
    endfunction

endpackage

// File: rtl/serial_arb_if.sv
// Requester-side bundle of the serial link arbiter. The requester side
// (master) drives requests and configuration; the arbiter (slave) drives
// the grant, status and the serial pins.
interface serial_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    import serial_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NCYC_W*NREQ-1:0] ncyc_bus;
    logic [DW*NREQ-1:0]     data_bus;
    logic                   y0;
    logic [CNT_W-1:0]       n0;
    logic [CNT_W-1:0]       n1;
    logic [CNT_W-1:0]       n2;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic                   sck;
    logic                   sdo;
    logic                   cs_n;

    modport master (
        output req, ncyc_bus, data_bus, y0, n0, n1, n2,
        input  gnt, busy, done, sck, sdo, cs_n
    );

    modport slave (
        input  req, ncyc_bus, data_bus, y0, n0, n1, n2,
        output gnt, busy, done, sck, sdo, cs_n
    );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin select: the first requester set after the
// pointer position wins, wrapping around.
module rr_arb #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;
    int   cand;

    // Scan requesters starting one past the pointer and stop at the first hit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/serial_arb.sv
// Round-robin arbiter and sequencer sharing one serial clock/data link
// among NREQ requesters. A granted transaction plays out a setup hold,
// then per bit a high half (sck = !y0) and a low half (sck = y0), shifting
// data MSB first, and ends with a one-cycle done pulse.
module serial_arb
    import serial_pkg::*;
#(
    parameter int   NREQ     = 4,
    parameter int   DW       = 32,
    parameter logic P_Y_INIT = 1'b0
) (
    input logic         clk,
    input logic         rst,
    serial_arb_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n0_lat;
    logic [CNT_W-1:0]  n1_lat;
    logic [CNT_W-1:0]  n2_lat;
    logic [NCYC_W-1:0] ncyc_lat;
    logic [NCYC_W-1:0] bits_sent;
    logic              y0_lat;
    logic [DW-1:0]     shreg;
    logic [IW-1:0]     ptr;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic              sck;
    logic              cs_n;

    logic [NREQ-1:0]   win_onehot;
    logic [IW-1:0]     win_idx;
    logic [NCYC_W-1:0] ncyc_sel;
    logic [NCYC_W-1:0] ncyc_eff;
    logic [DW-1:0]     data_sel;
    logic [DW-1:0]     shreg_load;
    int                sel;

    rr_arb #(.N(NREQ)) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (win_onehot),
        .idx   (win_idx)
    );

    // Pick the winner's bit count and data, clamp the count to 1..DW and
    // left-justify the data so its first bit sits at the shift-out end.
    always_comb begin
        sel      = int'(win_idx);
        ncyc_sel = bus.ncyc_bus[NCYC_W*sel +: NCYC_W];
        if (ncyc_sel == '0) begin
            ncyc_eff = NCYC_W'(1);
        end else if (int'(ncyc_sel) > DW) begin
            ncyc_eff = NCYC_W'(DW);
        end else begin
            ncyc_eff = ncyc_sel;
        end
        data_sel   = bus.data_bus[DW*sel +: DW];
        shreg_load = data_sel << (DW - int'(ncyc_eff));
    end

    // Transaction sequencer: grant, setup hold, bit halves, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched configuration is reset too; it is only a handful of flops, not a memory, and a known value keeps lint and X-checks quiet.
            state     <= S_IDLE;
            cnt       <= '0;
            n0_lat    <= '0;
            n1_lat    <= '0;
            n2_lat    <= '0;
            ncyc_lat  <= '0;
            bits_sent <= '0;
            y0_lat    <= 1'b0;
            shreg     <= '0;
            ptr       <= IW'(NREQ - 1);
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sck       <= P_Y_INIT;
            cs_n      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    sck <= bus.y0;
                    if (|bus.req) begin
                        gnt       <= win_onehot;
                        ptr       <= win_idx;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        cnt       <= '0;
                        bits_sent <= '0;
                        ncyc_lat  <= ncyc_eff;
                        shreg     <= shreg_load;
                        y0_lat    <= bus.y0;
                        n0_lat    <= clamp_n(bus.n0);
                        n1_lat    <= clamp_n(bus.n1);
                        n2_lat    <= clamp_n(bus.n2);
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == n0_lat - CNT_W'(1)) begin
                        cnt   <= '0;
                        sck   <= ~y0_lat;
                        state <= S_HI;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HI: begin
                    if (cnt == n1_lat - CNT_W'(1)) begin
                        cnt       <= '0;
                        sck       <= y0_lat;
                        shreg     <= {shreg[DW-2:0], 1'b0};
                        bits_sent <= bits_sent + NCYC_W'(1);
                        state     <= S_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LO: begin
                    if (cnt == n2_lat - CNT_W'(1)) begin
                        cnt <= '0;
                        if (bits_sent == ncyc_lat) begin
                            done  <= 1'b1;
                            cs_n  <= 1'b1;
                            sck   <= y0_lat;
                            shreg <= '0;
                            state <= S_DONE;
                        end else begin
                            sck   <= ~y0_lat;
                            state <= S_HI;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    sck   <= bus.y0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sck  = sck;
    assign bus.sdo  = shreg[DW-1];
    assign bus.cs_n = cs_n;

endmodule

// File: doc/serial_arb.md
Name: serial_arb

Overview:
Round-robin arbiter and sequencer that shares one serial clock/data link (sck, sdo, cs_n) among NREQ requesters.
- Grants one requester at a time.
- Latches that requester's bit count and data, plus the shared timing config.
- Plays out an idle-hold / high-half / low-half clock with MSB-first data, then signals done.
- Sits between several register-access engines and a single off-chip serial bus.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, maximum data bits per transaction
P_Y_INIT, 0, sck level while rst is asserted

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req  in  NREQ  request per requester; hold high until its done
ncyc_bus  in  8*NREQ  bit count per requester, slice i = [8i+7:8i]
data_bus  in  DW*NREQ  right-justified data per requester, slice i = [DWi+DW-1:DWi]
y0  in  1  idle sck level
n0  in  32  setup clocks before first sck edge
n1  in  32  clocks per first half-bit (sck = !y0)
n2  in  32  clocks per second half-bit (sck = y0)
gnt  out  NREQ  one-hot grant, registered
busy  out  1  high from grant through DONE
done  out  1  one-cycle completion pulse
sck  out  1  serial clock
sdo  out  1  serial data, MSB first
cs_n  out  1  active-low select, low while a transaction runs

Behaviour:
- Reset (async), all outputs: gnt=0, busy=0, done=0, sck=P_Y_INIT, sdo=0, cs_n=1. Also state=IDLE, RR pointer=NREQ-1 (so requester 0 wins first), phase counter=0.
- Reset asserted mid-transaction aborts it immediately; no done pulse.
- States: IDLE, SETUP, HI, LO, DONE.
- IDLE:
  - sck<=y0 every cycle.
  - If any req, pick the first requester set after the pointer, wrapping.
  - On the next edge: gnt one-hot, pointer<=winner, busy=1, cs_n=0, sck=y0, phase cnt=0, enter SETUP.
  - Latch the winner's config, y0, n0, n1, n2.
  - Config changes after the grant edge are ignored.
- Width rules:
  - n0, n1, n2 equal to 0 are treated as 1.
  - ncyc=0 is treated as 1; ncyc>DW is clamped to DW.
  - Shift register <= data << (DW - ncyc_eff); sdo = shreg[DW-1], valid from the grant edge.
- SETUP: lasts n0 clocks. When cnt==n0-1: cnt<=0, sck<=!y0, enter HI.
- HI: lasts n1 clocks. When cnt==n1-1: cnt<=0, sck<=y0, shreg shifts left by one with 0 fill, bit counter +1, enter LO.
- LO: lasts n2 clocks. When cnt==n2-1:
  - If bits sent == ncyc_eff: enter DONE.
  - Else: cnt<=0, sck<=!y0, enter HI.
- Consequence: sdo changes only at HI->LO and is stable across LO->HI.
- DONE: one cycle.
  - done=1, cs_n=1, sck=y0, sdo=0.
  - gnt and busy stay asserted this cycle and go 0 on the next edge.
  - Next state is IDLE.
- Timing:
  - Grant edge to DONE entry = n0 + ncyc_eff*(n1+n2) clocks.
  - At least one IDLE cycle between transactions, so back-to-back grants are 2 clocks apart after DONE.
- req deassertion during a transaction is ignored; the transaction completes.
- A requester that keeps req high after done is re-eligible, but only after the others (RR).
- Phase counter is 32-bit with no wrap hazard, because the compare happens before overflow for all legal n.

Decomposition:
- Shared package serial_pkg:
  - State encoding localparams (IDLE=0, SETUP=1, HI=2, LO=3, DONE=4).
  - CNT_W=32, NCYC_W=8.
  - Zero-to-one clamp function for n values.
- Sub-module rr_arb: combinational round-robin select.
  - Inputs: req and pointer.
  - Outputs: one-hot winner and winner index.
  - Reused elsewhere.
- FSM, counters and shift register stay in serial_arb.

Test Plan:
- Single request: NREQ=4, req=0001, y0=0, n0=2, n1=1, n2=1, ncyc=3, data=3'b101.
  - Expect sck per clock after grant = 0,0,1,0,1,0,1,0, then DONE.
  - Expect sdo = 1,1,1,0,0,1,1,0.
  - Expect done on clock 8, cs_n low for clocks 0..7.
- Round-robin: req=1111 held throughout.
  - Expect grant order 0,1,2,3,0.
  - Each grant 2 clocks after the previous done.
- Clamps: n0=n1=n2=0, ncyc=0, data LSB=1.
  - Expect 1 setup clock and a single bit sdo=1.
  - Expect done 3 clocks after the grant edge.
- Overlong/polarity: ncyc=40 with DW=32, y0=1.
  - Expect exactly 32 bits.
  - Expect sck idle high, dropping low in HI.
- Config stability: change n1 from 2 to 5 and y0 mid-transaction.
  - Expect timing and polarity unchanged until done.
  - The new values apply to the next grant.
- Reset mid-HI: assert rst.
  - Expect sck=P_Y_INIT, cs_n=1, gnt=0, no done.
  - After release, requester 0 wins first.
